// File: rtl/load_store_unit.sv
// Load/store unit: takes the ALU result as the effective address, issues one
// byte/half/word access to a data-memory port that may insert wait states,
// aligns and extends load data, and stalls the core until completion or fault.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for a request; decode and fault-check on valid
// ACCESS | mem_req held until mem_ready or the wait-state timer expires
// DONE   | one-cycle completion pulse, load_data updated
// ERR    | one-cycle completion pulse with err and err_code
module load_store_unit #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid,
  input  logic              is_load,
  input  logic              is_store,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [ADDR_W-1:0] wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ADDR_W-1:0] mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_rdata,
  output logic              stall,
  output logic              done,
  output logic [ADDR_W-1:0] load_data,
  output logic              err,
  output logic [1:0]        err_code
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE, ERR} state_t;

  // The wait-state timer counts down from TIMEOUT-1; reaching zero without
  // mem_ready means the access has used all TIMEOUT cycles.
  localparam logic [CNT_W-1:0] CNT_START = CNT_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        code_q, code_d;
  logic [ADDR_W-1:0] addr_q, wdata_q, load_data_q;
  logic [2:0]        funct3_q;
  logic              we_q;

  logic              req_start, legal_load, legal_store, illegal, misaligned;
  logic [ADDR_W-1:0] lane, load_ext;
  logic [3:0]        be_base;

  // Request decode and fault classification on the live inputs (used in IDLE only)
  always_comb begin
    req_start   = valid & (is_load | is_store);
    legal_load  = 1'b0;
    legal_store = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b010: begin
        legal_load  = 1'b1;
        legal_store = 1'b1;
      end
      3'b100, 3'b101: legal_load = 1'b1;
      default: ;
    endcase
    illegal    = (is_load & is_store) | (is_load & ~legal_load) | (is_store & ~legal_store);
    misaligned = ((funct3[1:0] == 2'b01) & addr[0]) |
                 ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00));
  end

  // Next-state, timer and fault-code logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    case (state_q)
      IDLE: begin
        if (req_start) begin
          if (illegal) begin
            state_d = ERR;
            code_d  = 2'b10;
          end else if (misaligned) begin
            state_d = ERR;
            code_d  = 2'b01;
          end else begin
            state_d = ACCESS;
            cnt_d   = CNT_START;
          end
        end
      end
      ACCESS: begin
        // ready on the last allowed cycle still completes normally
        if (mem_ready) begin
          state_d = DONE;
        end else if (cnt_q == '0) begin
          state_d = ERR;
          code_d  = 2'b11;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register, timer and fault code
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      code_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
    end
  end

  // Request latch: inputs are frozen at acceptance so later changes are ignored
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= 3'b000;
      we_q     <= 1'b0;
    end else if (state_q == IDLE && req_start) begin
      addr_q   <= addr;
      wdata_q  <= wdata;
      funct3_q <= funct3;
      we_q     <= is_store;
    end
  end

  // Load lane extraction and sign/zero extension
  always_comb begin
    lane = mem_rdata >> {addr_q[1:0], 3'b000};
    case (funct3_q)
      3'b000:  load_ext = {{(ADDR_W-8){lane[7]}}, lane[7:0]};
      3'b001:  load_ext = {{(ADDR_W-16){lane[15]}}, lane[15:0]};
      3'b100:  load_ext = {{(ADDR_W-8){1'b0}}, lane[7:0]};
      3'b101:  load_ext = {{(ADDR_W-16){1'b0}}, lane[15:0]};
      default: load_ext = lane;
    endcase
  end

  // Load result register, held until the next completed load
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_data_q <= '0;
    end else if (state_q == ACCESS && mem_ready && !we_q) begin
      load_data_q <= load_ext;
    end
  end

  // Memory port: driven only in ACCESS, zero otherwise
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = 4'b0000;
    case (funct3_q[1:0])
      2'b00:   be_base = 4'b0001;
      2'b01:   be_base = 4'b0011;
      default: be_base = 4'b1111;
    endcase
    if (state_q == ACCESS) begin
      mem_req  = 1'b1;
      mem_we   = we_q;
      mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
      mem_be   = be_base << addr_q[1:0];
      case (funct3_q[1:0])
        2'b00:   mem_wdata = {(ADDR_W/8){wdata_q[7:0]}};
        2'b01:   mem_wdata = {(ADDR_W/16){wdata_q[15:0]}};
        default: mem_wdata = wdata_q;
      endcase
    end
  end

  // Core handshake outputs; stall is forced low while reset is asserted
  always_comb begin
    stall     = ~reset & valid &
                ((state_q == ACCESS) | ((state_q == IDLE) & (is_load | is_store)));
    done      = (state_q == DONE) | (state_q == ERR);
    err       = (state_q == ERR);
    err_code  = (state_q == ERR) ? code_q : 2'b00;
    load_data = load_data_q;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed and randomized bench for load_store_unit with a small timeout so
// the fault path is reachable quickly. Expected values come from an
// arithmetic reference model of the access rules.
module tb_load_store_unit;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid, is_load, is_store, mem_ready;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, mem_rdata;
  logic        mem_req, mem_we, stall, done, err;
  logic [31:0] mem_addr, mem_wdata, load_data;
  logic [3:0]  mem_be;
  logic [1:0]  err_code;

  int total = 0;
  int bad   = 0;

  load_store_unit #(.ADDR_W(32), .TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .valid(valid), .is_load(is_load), .is_store(is_store),
    .funct3(funct3), .addr(addr), .wdata(wdata), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .stall(stall), .done(done), .load_data(load_data),
    .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // access size in bytes from funct3
  function automatic int ref_size(input logic [2:0] f3);
    case (f3 % 4)
      0:       return 1;
      1:       return 2;
      default: return 4;
    endcase
  endfunction

  // 0 ok, 1 misaligned, 2 illegal
  function automatic logic [1:0] ref_code(input logic il, input logic is,
                                          input logic [2:0] f3, input logic [31:0] a);
    bit ok_ld, ok_st;
    ok_ld = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
    ok_st = (f3 <= 2);
    if (il && is) return 2'd2;
    if ((il && !ok_ld) || (is && !ok_st)) return 2'd2;
    if ((a % ref_size(f3)) != 0) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [31:0] ref_be(input logic [2:0] f3, input logic [31:0] a);
    int v;
    v = ((1 << ref_size(f3)) - 1) << (a % 4);
    return 32'(v & 15);
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] wd);
    longint v;
    case (ref_size(f3))
      1:       v = longint'(wd & 32'hFF) * 64'h01010101;
      2:       v = longint'(wd & 32'hFFFF) * 64'h00010001;
      default: v = longint'(wd);
    endcase
    return v[31:0];
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rd);
    longint v, span;
    int sz;
    sz   = ref_size(f3);
    span = longint'(1) << (8 * sz);
    v    = (longint'(rd) >> (8 * (a % 4))) % span;
    if (f3 < 4 && sz < 4 && v >= span / 2) v = v - span;
    return v[31:0];
  endfunction

  // One complete request from acceptance to return to IDLE. wait_n is the
  // number of ACCESS cycles without ready before ready is given; wait_n >= TO
  // never gives ready.
  task automatic run_op(input string name, input logic il, input logic is,
                        input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rd, input int wait_n);
    logic [1:0]  code;
    logic [31:0] exp_ld;
    bit          tmo;
    int          n_acc;
    code   = ref_code(il, is, f3, a);
    exp_ld = ref_load(f3, a, rd);
    tmo    = (wait_n >= TO);
    n_acc  = tmo ? TO : wait_n + 1;
    @(posedge clk); #1;
    valid = 1'b1; is_load = il; is_store = is; funct3 = f3; addr = a; wdata = wd;
    mem_ready = 1'b0; mem_rdata = $urandom;
    @(negedge clk);
    check({name, ":idle_stall"}, 32'(stall), 32'd1);
    check({name, ":idle_req"}, 32'(mem_req), 32'd0);
    if (code != 2'd0) begin
      @(posedge clk); #1;
      @(negedge clk);
      check({name, ":flt_done"}, 32'(done), 32'd1);
      check({name, ":flt_err"}, 32'(err), 32'd1);
      check({name, ":flt_code"}, 32'(err_code), 32'(code));
      check({name, ":flt_req"}, 32'(mem_req), 32'd0);
      check({name, ":flt_stall"}, 32'(stall), 32'd0);
    end else begin
      for (int k = 1; k <= n_acc; k++) begin
        @(posedge clk); #1;
        if (!tmo && k == wait_n + 1) begin
          mem_ready = 1'b1; mem_rdata = rd;
        end else begin
          mem_ready = 1'b0; mem_rdata = $urandom;
        end
        @(negedge clk);
        check({name, ":acc_req"}, 32'(mem_req), 32'd1);
        check({name, ":acc_we"}, 32'(mem_we), 32'(is));
        check({name, ":acc_addr"}, mem_addr, a & 32'hFFFF_FFFC);
        check({name, ":acc_be"}, 32'(mem_be), ref_be(f3, a));
        if (is) check({name, ":acc_wdata"}, mem_wdata, ref_wdata(f3, wd));
        check({name, ":acc_stall"}, 32'(stall), 32'd1);
        check({name, ":acc_done"}, 32'(done), 32'd0);
        addr = $urandom; wdata = $urandom; funct3 = 3'($urandom_range(0, 7));
      end
      @(posedge clk); #1;
      mem_ready = 1'b0;
      @(negedge clk);
      check({name, ":end_done"}, 32'(done), 32'd1);
      check({name, ":end_err"}, 32'(err), 32'(tmo));
      check({name, ":end_code"}, 32'(err_code), tmo ? 32'd3 : 32'd0);
      check({name, ":end_req"}, 32'(mem_req), 32'd0);
      check({name, ":end_stall"}, 32'(stall), 32'd0);
      if (il && !tmo) check({name, ":load_data"}, load_data, exp_ld);
    end
    @(posedge clk); #1;
    valid = 1'b0; is_load = 1'b0; is_store = 1'b0;
    @(negedge clk);
    check({name, ":post_done"}, 32'(done), 32'd0);
    check({name, ":post_code"}, 32'(err_code), 32'd0);
    check({name, ":post_req"}, 32'(mem_req), 32'd0);
    if (il && code == 2'd0 && !tmo) check({name, ":ld_hold"}, load_data, exp_ld);
  endtask

  initial begin
    logic        il, is;
    int          sel;
    reset = 1'b1; valid = 1'b0; is_load = 1'b0; is_store = 1'b0; funct3 = 3'b000;
    addr = '0; wdata = '0; mem_ready = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_code", 32'(err_code), 32'd0);
    check("rst_ld", load_data, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_be", 32'(mem_be), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    reset = 1'b0;

    run_op("lw0",   1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0);
    run_op("lb",    1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF7F01, 0);
    run_op("lbu",   1, 0, 3'b100, 32'h103, 32'h0, 32'h80FF7F01, 0);
    run_op("lh",    1, 0, 3'b001, 32'h102, 32'h0, 32'h80FF7F01, 0);
    run_op("lhu",   1, 0, 3'b101, 32'h100, 32'h0, 32'h80FF7F01, 0);
    run_op("sb",    0, 1, 3'b000, 32'h201, 32'h12345678, 32'h0, 0);
    run_op("sh",    0, 1, 3'b001, 32'h202, 32'h12345678, 32'h0, 0);
    run_op("lw_w5", 1, 0, 3'b010, 32'h104, 32'h0, 32'h0BADF00D, 4);
    run_op("lw_to", 1, 0, 3'b010, 32'h108, 32'h0, 32'h11111111, TO);
    run_op("lw_w8", 1, 0, 3'b010, 32'h10C, 32'h0, 32'hCAFEF00D, TO - 1);
    run_op("lw_mis", 1, 0, 3'b010, 32'h102, 32'h0, 32'h0, 0);
    run_op("ld_011", 1, 0, 3'b011, 32'h100, 32'h0, 32'h0, 0);
    run_op("sbu",    0, 1, 3'b100, 32'h100, 32'h0, 32'h0, 0);
    run_op("both",   1, 1, 3'b010, 32'h100, 32'h0, 32'h0, 0);

    // reset in the middle of an access
    @(posedge clk); #1;
    valid = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h300;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("mid_req_before", 32'(mem_req), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("mid_req_async", 32'(mem_req), 32'd0);
    check("mid_stall_async", 32'(stall), 32'd0);
    check("mid_done_async", 32'(done), 32'd0);
    @(posedge clk); #1;
    check("mid_done_after", 32'(done), 32'd0);
    valid = 1'b0; is_load = 1'b0;
    reset = 1'b0;
    run_op("lw_post_rst", 1, 0, 3'b010, 32'h304, 32'h0, 32'h5A5A1234, 1);

    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 9);
      il  = (sel <= 5);
      is  = (sel == 0) || (sel >= 6);
      run_op("rnd", il, is, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
             $urandom_range(0, TO + 1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
